// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester handshakes (instruction fetch and load/store)
//   and the shared memory port that mem_port_arbiter multiplexes.
//
//   Fetch requester : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   Data requester  : d_req, d_we, d_func, d_addr, d_wdata
//                     -> d_gnt, d_rvalid, d_rdata
//   Memory port     : mem_addr, mem_func, mem_wdata, mem_rw -> mem_rdata
//
//   slave  : the arbiter's view (consumes requests and read data, drives
//            grants, responses and the memory command).
//   master : the surrounding core/memory view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [2:0]  mem_func;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_func, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_func, mem_wdata, mem_rw,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_func, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_func, mem_wdata, mem_rw,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between the instruction-fetch path
//   and the load/store path. One transaction at a time: the winner's command
//   is registered onto mem_* and held for LATENCY cycles, then mem_rdata is
//   captured and returned to the winner with a one-cycle rvalid pulse.
//   Simultaneous requests are resolved round-robin (fetch wins the first
//   conflict after reset).
//
//   Parameters : LATENCY (1..15) cycles from address presentation to
//                valid mem_rdata.
//   Ports      : clk, rst (asynchronous, active-high)
//                bus (mem_port_arbiter_if.slave) - both requester
//                handshakes plus the memory port. All outputs registered.
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [2:0] FUNC_WORD = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       owner_q;   // 0 = fetch, 1 = data
  logic       last_q;    // most recent owner, drives round-robin
  logic       we_q;      // current transaction is a store
  logic [3:0] cnt_q;

  logic       grant_if;
  logic       grant_d;
  logic       done;

  // Next state and accept/complete decisions
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        // Fetch wins unless data also requests and fetch owned last.
        if (bus.if_req && (!bus.d_req || last_q)) begin
          grant_if = 1'b1;
        end else if (bus.d_req) begin
          grant_d = 1'b1;
        end
        if (grant_if || grant_d) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (grant_if || grant_d) begin
        owner_q <= grant_d;
        last_q  <= grant_d;
        we_q    <= grant_d & bus.d_we;
        cnt_q   <= CNT_INIT;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Registered outputs: handshakes, responses and the memory command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_gnt    <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_gnt     <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_func  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rw    <= 1'b0;
    end else begin
      bus.if_gnt    <= grant_if;
      bus.d_gnt     <= grant_d;
      bus.if_rvalid <= done & ~owner_q;
      bus.d_rvalid  <= done & owner_q;
      // Write enable lives only in the grant cycle so a store lands once.
      bus.mem_rw    <= grant_d & bus.d_we;

      if (done && !owner_q) begin
        bus.if_rdata <= bus.mem_rdata;
      end
      if (done && owner_q && !we_q) begin
        bus.d_rdata <= bus.mem_rdata;
      end

      if (grant_if) begin
        bus.mem_addr  <= bus.if_addr;
        bus.mem_func  <= FUNC_WORD;
        bus.mem_wdata <= '0;
      end else if (grant_d) begin
        bus.mem_addr  <= bus.d_addr;
        bus.mem_func  <= bus.d_func;
        bus.mem_wdata <= bus.d_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: one instance at LATENCY=2 and one at
//   LATENCY=1, each with its own interface, sharing a word-addressed memory
//   model (256 words, index = addr[9:2]). Directed scenarios followed by a
//   randomized run checked against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fill;

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus2 ();

  mem_port_arbiter #(.LATENCY(LAT_A)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.LATENCY(LAT_B)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] init_word(int i);
    if (i == 0) return 32'h0000_0013;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  assign bus1.mem_rdata = dmem[bus1.mem_addr[9:2]];
  assign bus2.mem_rdata = dmem[bus2.mem_addr[9:2]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_word(i);
    end else begin
      if (bus1.mem_rw) dmem[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
      if (bus2.mem_rw) dmem[bus2.mem_addr[9:2]] <= bus2.mem_wdata;
    end
  end

  function automatic logic [135:0] outs1();
    return {bus1.if_gnt, bus1.if_rvalid, bus1.if_rdata, bus1.d_gnt, bus1.d_rvalid,
            bus1.d_rdata, bus1.mem_addr, bus1.mem_func, bus1.mem_wdata, bus1.mem_rw};
  endfunction

  function automatic logic [135:0] outs2();
    return {bus2.if_gnt, bus2.if_rvalid, bus2.if_rdata, bus2.d_gnt, bus2.d_rvalid,
            bus2.d_rdata, bus2.mem_addr, bus2.mem_func, bus2.mem_wdata, bus2.mem_rw};
  endfunction

  task automatic idle_inputs();
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_func = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
    bus2.if_req = 0; bus2.if_addr = 0; bus2.d_req = 0; bus2.d_we = 0;
    bus2.d_func = 0; bus2.d_addr = 0; bus2.d_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; fill = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; fill = 0;
  endtask

  task automatic test_reset();
    rst = 0; fill = 0;
    idle_inputs();
    #13;
    rst = 1; fill = 1;
    #1;
    n_checks++;
    if (outs1() !== '0) $display("FAIL reset_async_lat2: got %h expected 0", outs1());
    else n_pass++;
    n_checks++;
    if (outs2() !== '0) $display("FAIL reset_async_lat1: got %h expected 0", outs2());
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; fill = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if ({bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid,
           bus2.if_gnt, bus2.d_gnt, bus2.if_rvalid, bus2.d_rvalid} !== 8'h00)
        $display("FAIL reset_idle cycle %0d: got %b%b%b%b %b%b%b%b expected all 0", k,
                 bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid,
                 bus2.if_gnt, bus2.d_gnt, bus2.if_rvalid, bus2.d_rvalid);
      else n_pass++;
    end
  endtask

  task automatic test_fetch();
    bus1.if_addr = 32'h8000_0000;
    bus1.if_req  = 1;
    tick();
    n_checks++;
    if ({bus1.if_gnt, bus1.if_rvalid, bus1.mem_addr, bus1.mem_func, bus1.mem_wdata, bus1.mem_rw}
        !== {1'b1, 1'b0, 32'h8000_0000, 3'b010, 32'h0, 1'b0})
      $display("FAIL fetch_grant: got gnt=%b rv=%b addr=%h func=%b wd=%h rw=%b expected 1 0 80000000 010 0 0",
               bus1.if_gnt, bus1.if_rvalid, bus1.mem_addr, bus1.mem_func, bus1.mem_wdata, bus1.mem_rw);
    else n_pass++;
    bus1.if_req = 0;
    tick();
    n_checks++;
    if ({bus1.if_gnt, bus1.if_rvalid} !== 2'b00)
      $display("FAIL fetch_wait: got gnt=%b rv=%b expected 0 0", bus1.if_gnt, bus1.if_rvalid);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus1.if_rvalid, bus1.if_rdata} !== {1'b1, 32'h0000_0013})
      $display("FAIL fetch_resp: got rv=%b rdata=%h expected 1 00000013", bus1.if_rvalid, bus1.if_rdata);
    else n_pass++;
    n_checks++;
    if ({bus1.d_gnt, bus1.d_rvalid, bus1.d_rdata} !== 34'h0)
      $display("FAIL fetch_d_untouched: got gnt=%b rv=%b rdata=%h expected 0 0 0",
               bus1.d_gnt, bus1.d_rvalid, bus1.d_rdata);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus1.if_rvalid, bus1.if_rdata} !== {1'b0, 32'h0000_0013})
      $display("FAIL fetch_hold: got rv=%b rdata=%h expected 0 00000013", bus1.if_rvalid, bus1.if_rdata);
    else n_pass++;
  endtask

  task automatic test_store_load();
    bus1.d_we = 1; bus1.d_addr = 32'h8000_0100; bus1.d_wdata = 32'hCAFE_F00D;
    bus1.d_func = 3'b010; bus1.d_req = 1;
    tick();
    n_checks++;
    if ({bus1.d_gnt, bus1.mem_rw, bus1.mem_addr, bus1.mem_wdata, bus1.mem_func}
        !== {1'b1, 1'b1, 32'h8000_0100, 32'hCAFE_F00D, 3'b010})
      $display("FAIL store_grant: got gnt=%b rw=%b addr=%h wd=%h func=%b expected 1 1 80000100 cafef00d 010",
               bus1.d_gnt, bus1.mem_rw, bus1.mem_addr, bus1.mem_wdata, bus1.mem_func);
    else n_pass++;
    bus1.d_req = 0;
    tick();
    n_checks++;
    if ({bus1.d_gnt, bus1.mem_rw, bus1.d_rvalid} !== 3'b000)
      $display("FAIL store_rw_once: got gnt=%b rw=%b rv=%b expected 0 0 0",
               bus1.d_gnt, bus1.mem_rw, bus1.d_rvalid);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus1.d_rvalid, bus1.d_rdata, bus1.mem_rw} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL store_resp: got rv=%b rdata=%h rw=%b expected 1 0 0",
               bus1.d_rvalid, bus1.d_rdata, bus1.mem_rw);
    else n_pass++;
    tick();
    bus1.d_we = 0; bus1.d_req = 1;
    tick();
    n_checks++;
    if ({bus1.d_gnt, bus1.mem_rw} !== 2'b10)
      $display("FAIL load_grant: got gnt=%b rw=%b expected 1 0", bus1.d_gnt, bus1.mem_rw);
    else n_pass++;
    bus1.d_req = 0;
    tick();
    tick();
    n_checks++;
    if ({bus1.d_rvalid, bus1.d_rdata, bus1.if_rdata} !== {1'b1, 32'hCAFE_F00D, 32'h0000_0013})
      $display("FAIL load_resp: got rv=%b rdata=%h if_rdata=%h expected 1 cafef00d 00000013",
               bus1.d_rvalid, bus1.d_rdata, bus1.if_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    logic [3:0] exp_ctl;
    bit         fetch_turn;
    do_reset();
    bus1.if_addr = 32'h8000_0004;
    bus1.d_addr  = 32'h8000_0008; bus1.d_we = 0; bus1.d_func = 3'b010;
    bus1.if_req  = 1; bus1.d_req = 1;
    for (int k = 0; k < 4 * (LAT_A + 1); k++) begin
      tick();
      fetch_turn = ((k / (LAT_A + 1)) % 2) == 0;
      exp_ctl = {(k % (LAT_A + 1) == 0) && fetch_turn, (k % (LAT_A + 1) == 0) && !fetch_turn,
                 (k % (LAT_A + 1) == LAT_A) && fetch_turn, (k % (LAT_A + 1) == LAT_A) && !fetch_turn};
      n_checks++;
      if ({bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid} !== exp_ctl)
        $display("FAIL conflict_seq cycle %0d: got %b%b%b%b expected %b", k,
                 bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid, exp_ctl);
      else n_pass++;
      if (k % (LAT_A + 1) == LAT_A) begin
        n_checks++;
        if (fetch_turn ? (bus1.if_rdata !== init_word(1)) : (bus1.d_rdata !== init_word(2)))
          $display("FAIL conflict_data cycle %0d: got if=%h d=%h expected %h", k,
                   bus1.if_rdata, bus1.d_rdata, fetch_turn ? init_word(1) : init_word(2));
        else n_pass++;
      end
    end
    bus1.if_req = 0; bus1.d_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset_busy();
    bit seen_rv;
    bus1.d_we = 0; bus1.d_addr = 32'h8000_0100; bus1.d_func = 3'b010; bus1.d_req = 1;
    tick();
    n_checks++;
    if (bus1.d_gnt !== 1'b1) $display("FAIL rstbusy_grant: got %b expected 1", bus1.d_gnt);
    else n_pass++;
    bus1.d_req = 0;
    tick();
    #3;
    rst = 1;
    #1;
    n_checks++;
    if (outs1() !== '0) $display("FAIL rstbusy_async: got %h expected 0", outs1());
    else n_pass++;
    seen_rv = 0;
    tick();
    seen_rv |= bus1.d_rvalid;
    @(negedge clk);
    rst = 0;
    repeat (4) begin
      tick();
      seen_rv |= bus1.d_rvalid;
    end
    n_checks++;
    if (seen_rv !== 1'b0) $display("FAIL rstbusy_no_rvalid: got %b expected 0", seen_rv);
    else n_pass++;
    bus1.if_addr = 32'h8000_0000; bus1.if_req = 1;
    tick();
    n_checks++;
    if (bus1.if_gnt !== 1'b1) $display("FAIL rstbusy_fetch_grant: got %b expected 1", bus1.if_gnt);
    else n_pass++;
    bus1.if_req = 0;
    tick();
    tick();
    n_checks++;
    if ({bus1.if_rvalid, bus1.if_rdata} !== {1'b1, 32'h0000_0013})
      $display("FAIL rstbusy_fetch_resp: got rv=%b rdata=%h expected 1 00000013",
               bus1.if_rvalid, bus1.if_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back_lat1();
    bus2.d_we = 0; bus2.d_func = 3'b010; bus2.d_addr = 32'h8000_0000 | (32'd3 << 2);
    bus2.d_req = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if ({bus2.d_gnt, bus2.d_rvalid, bus2.mem_rw, bus2.if_gnt} !== {k % 2 == 0, k % 2 == 1, 1'b0, 1'b0})
        $display("FAIL b2b_lat1_ctl cycle %0d: got gnt=%b rv=%b rw=%b ifg=%b expected %b %b 0 0", k,
                 bus2.d_gnt, bus2.d_rvalid, bus2.mem_rw, bus2.if_gnt, k % 2 == 0, k % 2 == 1);
      else n_pass++;
      if (k % 2 == 1) begin
        n_checks++;
        if (bus2.d_rdata !== init_word(3 + k / 2))
          $display("FAIL b2b_lat1_data cycle %0d: got %h expected %h", k, bus2.d_rdata, init_word(3 + k / 2));
        else n_pass++;
      end else begin
        n_checks++;
        if (bus2.mem_addr !== (32'h8000_0000 | 32'((3 + k / 2) << 2)))
          $display("FAIL b2b_lat1_addr cycle %0d: got %h expected %h", k, bus2.mem_addr,
                   32'h8000_0000 | 32'((3 + k / 2) << 2));
        else n_pass++;
        if (k / 2 < 3) bus2.d_addr = 32'h8000_0000 | 32'((4 + k / 2) << 2);
        else bus2.d_req = 0;
      end
    end
    tick();
  endtask

  task automatic test_random();
    int          free_edge;
    int          resp_edge;
    logic        last_m, owner_m, we_m, g_if, g_d;
    logic [31:0] val_m, e_if_rdata, e_d_rdata, e_addr, e_wdata;
    logic [2:0]  e_func;
    logic [4:0]  e_ctl;   // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_rw}
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    free_edge = 0; resp_edge = -1; last_m = 1; owner_m = 0; we_m = 0; val_m = 0;
    e_if_rdata = 0; e_d_rdata = 0; e_addr = 0; e_wdata = 0; e_func = 0;
    for (int n = 0; n < 400; n++) begin
      if (!bus1.if_req && $urandom_range(0, 2) != 0) begin
        bus1.if_addr = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
        bus1.if_req  = 1;
      end
      if (!bus1.d_req && $urandom_range(0, 2) != 0) begin
        bus1.d_we    = 1'($urandom_range(0, 1));
        bus1.d_func  = 3'($urandom_range(0, 7));
        bus1.d_addr  = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
        bus1.d_wdata = $urandom;
        bus1.d_req   = 1;
      end
      @(posedge clk);
      g_if = 0; g_d = 0; e_ctl = '0;
      if (n == resp_edge) begin
        if (owner_m) e_ctl[1] = 1'b1; else e_ctl[2] = 1'b1;
        if (!owner_m) e_if_rdata = val_m;
        else if (!we_m) e_d_rdata = val_m;
      end
      if (n >= free_edge && (bus1.if_req || bus1.d_req)) begin
        owner_m   = bus1.d_req && (!bus1.if_req || !last_m);
        last_m    = owner_m;
        resp_edge = n + LAT_A;
        free_edge = n + LAT_A + 1;
        if (owner_m) begin
          we_m = bus1.d_we; e_addr = bus1.d_addr; e_func = bus1.d_func; e_wdata = bus1.d_wdata;
          e_ctl[3] = 1'b1; e_ctl[0] = we_m; g_d = 1;
        end else begin
          we_m = 0; e_addr = bus1.if_addr; e_func = 3'b010; e_wdata = 0;
          e_ctl[4] = 1'b1; g_if = 1;
        end
        val_m = ref_mem[e_addr[9:2]];
        if (we_m) ref_mem[e_addr[9:2]] = e_wdata;
      end
      #1;
      n_checks++;
      if ({bus1.if_gnt, bus1.d_gnt, bus1.if_rvalid, bus1.d_rvalid, bus1.mem_rw} !== e_ctl)
        $display("FAIL random_ctl edge %0d: got %b%b%b%b%b expected %b", n, bus1.if_gnt, bus1.d_gnt,
                 bus1.if_rvalid, bus1.d_rvalid, bus1.mem_rw, e_ctl);
      else n_pass++;
      n_checks++;
      if ({bus1.if_rdata, bus1.d_rdata} !== {e_if_rdata, e_d_rdata})
        $display("FAIL random_rdata edge %0d: got if=%h d=%h expected if=%h d=%h", n,
                 bus1.if_rdata, bus1.d_rdata, e_if_rdata, e_d_rdata);
      else n_pass++;
      n_checks++;
      if ({bus1.mem_addr, bus1.mem_func, bus1.mem_wdata} !== {e_addr, e_func, e_wdata})
        $display("FAIL random_mem edge %0d: got %h %b %h expected %h %b %h", n, bus1.mem_addr,
                 bus1.mem_func, bus1.mem_wdata, e_addr, e_func, e_wdata);
      else n_pass++;
      if (g_if) begin
        if ($urandom_range(0, 1) == 1) bus1.if_addr = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
        else bus1.if_req = 0;
      end
      if (g_d) begin
        if ($urandom_range(0, 1) == 1) begin
          bus1.d_we    = 1'($urandom_range(0, 1));
          bus1.d_func  = 3'($urandom_range(0, 7));
          bus1.d_addr  = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
          bus1.d_wdata = $urandom;
        end else begin
          bus1.d_req = 0;
        end
      end
    end
    bus1.if_req = 0; bus1.d_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_conflict();
    test_reset_busy();
    test_back_to_back_lat1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between the instruction-fetch path and the load/store path. Each requester sees a request/grant/response handshake. The arbiter serialises transactions, holds memory address, control and write data stable for a fixed read latency, and returns read data to the winning requester. On conflict it arbitrates round-robin. It sits between the core's multi-cycle pipeline sequencer and the `memory` instance.

## Interface
Parameters:
- `LATENCY`, default 2: memory cycles from address presentation to valid `mem_rdata`. Legal range is 1..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `if_req` in 1: fetch request. It is held until `if_gnt`. `if_addr` must be stable while `if_req` is high.
- `if_addr` in 32: fetch byte address. The fetch is always a word read (func 3'b010).
- `if_gnt` out 1: one-cycle pulse; the fetch request was accepted.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out 32: fetched word. It is held until the next fetch response.
- `d_req` in 1: data request. `d_we`, `d_func`, `d_addr` and `d_wdata` must be stable while `d_req` is high.
- `d_we` in 1: 1 means store, 0 means load.
- `d_func` in 3: width/sign code (RISC-V funct3), passed to memory.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: one-cycle pulse; the data request was accepted.
- `d_rvalid` out 1: one-cycle pulse; the load data is valid, or the store is complete.
- `d_rdata` out 32: load data. It is updated on loads only.
- `mem_addr` out 32: memory address.
- `mem_func` out 3: memory width code.
- `mem_wdata` out 32: memory write data.
- `mem_rw` out 1: memory write enable.
- `mem_rdata` in 32: memory read data.

## Operation
State machine:
- States are IDLE and BUSY.
- `owner` is a 1-bit register: 0 = fetch, 1 = data.
- `last` is a 1-bit register holding the most recent owner.
- `cnt` is a 4-bit down-counter.

IDLE, at each edge:
- If neither request is high: stay in IDLE.
- If only one request is high: accept it.
- If both are high: accept the one whose number ≠ `last`.
- On accept:
  - `owner` and `last` ← the winner.
  - The winner's `addr`, `func` and `wdata` are latched onto the `mem_*` outputs. For fetch, `mem_func`=3'b010 and `mem_wdata`=0.
  - `mem_rw` ← `d_we` for a data request, 0 for fetch.
  - The winner's `gnt` ← 1.
  - `cnt` ← `LATENCY`-1.
  - Go to BUSY.

BUSY, at each edge:
- `gnt` ← 0.
- `mem_rw` ← 0, so the store is written exactly once, in the first BUSY cycle.
- If `cnt` ≠ 0: `cnt` ← `cnt`-1.
- If `cnt` = 0:
  - The owner's `rvalid` ← 1.
  - On a fetch or load, the owner's `rdata` ← `mem_rdata`.
  - Go to IDLE.
- Requests are ignored while in BUSY.

Outside BUSY:
- `rvalid` clears at the next edge after it is set.
- `mem_addr`, `mem_func` and `mem_wdata` hold their last values in IDLE.

Requester rules:
- A requester must drop `req` on the edge ending its `gnt` cycle, or keep it high to request back-to-back transactions.
- A `req` that is still high during the `rvalid` cycle is treated as a new request at that cycle's edge.
- Round-robin then applies, so a continuously requesting pair alternates.

Reset:
- `rst` high asynchronously forces IDLE, `last`=1 (fetch wins the first conflict), `cnt`=0, and every output to 0:
  - `if_gnt`, `if_rvalid`, `if_rdata`
  - `d_gnt`, `d_rvalid`, `d_rdata`
  - `mem_addr`, `mem_func`, `mem_wdata`, `mem_rw`
- Reset during BUSY abandons the transaction: no `rvalid` is issued, and `mem_rw` drops immediately.

## Timing
- Accept edge E0. `gnt` is high and `mem_*` are valid in cycle E0..E1.
- `mem_rdata` is sampled at edge E(`LATENCY`). `rvalid` is high in cycle E`LATENCY`..E`LATENCY`+1.
- Request-to-response latency is `LATENCY` cycles after acceptance. Peak throughput is one transaction per `LATENCY`+1 cycles.
- With `LATENCY`=1: BUSY lasts one cycle, and `gnt` and the store write share that cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `rst` mid-clock with `LATENCY`=2 → all outputs 0 immediately. After release, idle with no requests → no `gnt`/`rvalid` for 10 cycles.
- **Fetch:** `mem[0]`=0x00000013, `if_req`=1, `if_addr`=0x80000000 → `if_gnt` one cycle after the accept edge. `if_rvalid` arrives 2 cycles after accept, with `if_rdata`=0x00000013. `d_*` outputs are untouched.
- **Store then load:**
  - Store `d_we`=1, `d_addr`=0x80000100, `d_wdata`=0xCAFEF00D, `d_func`=3'b010 → `mem_rw` high for exactly one cycle. `d_rvalid` pulses; `d_rdata` is unchanged.
  - Subsequent load of the same address → `d_rdata`=0xCAFEF00D.
- **Conflict after reset:** `if_req` and `d_req` rise in the same cycle and stay high → fetch is granted first, then data, then fetch, alternating. Each grant is spaced `LATENCY`+1 cycles.
- **Reset mid-BUSY:** accept a load, then assert `rst` in the second BUSY cycle → `d_rvalid` never pulses. After release, a new fetch completes normally.
- **`LATENCY`=1 back-to-back:** a data-only stream of 4 loads held with `d_req`=1 → 4 `d_rvalid` pulses on alternating cycles. Each carries the correct `mem_rdata`.
